// File: rtl/fifo_serial_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_serial_transmitter_if
// Description : FIFO read-port bundle between the queue and its serial
//               transmitter. The transmitter side owns the pop request.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_serial_transmitter_if;
   logic       Fifo_Read_Enable_Out;
   logic       Fifo_Empty_In;
   logic [7:0] Fifo_Data_In;

   // Transmitter side: issues pops, observes empty flag and read data
   modport master (
      output Fifo_Read_Enable_Out,
      input  Fifo_Empty_In,
      input  Fifo_Data_In
   );

   // FIFO side: answers pops with data and reports occupancy
   modport slave (
      input  Fifo_Read_Enable_Out,
      output Fifo_Empty_In,
      output Fifo_Data_In
   );
endinterface
`default_nettype wire

// File: rtl/fifo_serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_serial_transmitter
// Description : Drains an 8-bit FIFO and sends each byte as an asynchronous
//               frame: start bit, 8 data bits LSB first, optional parity,
//               stop bit. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_serial_transmitter #(
   parameter int CLKS_PER_BIT  = 16,
   parameter int PARITY_ENABLE = 0,
   parameter int PARITY_ODD    = 0
) (
   input  wire                       Clk_In,
   input  wire                       Reset_In,
   input  wire                       Enable_In,
   fifo_serial_transmitter_if.master fifo,
   output logic                      Tx_Out,
   output logic                      Busy_Out,
   output logic                      Frame_Done_Out
);

   localparam int               BAUD_W     = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic             USE_PARITY = (PARITY_ENABLE != 0);
   localparam logic             PARITY_INV = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } state_t;

   state_t            state, state_next;
   logic [BAUD_W-1:0] baud_cnt, baud_next;
   logic [2:0]        bit_cnt, bit_next;
   logic [7:0]        shift, shift_next;
   logic              parity, parity_next;
   logic              tx_next, read_next, done_next, busy_next;
   logic              baud_wrap;

   assign baud_wrap = (baud_cnt == BAUD_LAST);

   // State, counters, data path and registered outputs; async reset idles the line
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         state                     <= IDLE;
         baud_cnt                  <= '0;
         bit_cnt                   <= '0;
         shift                     <= '0;
         parity                    <= 1'b0;
         Tx_Out                    <= 1'b1;
         Busy_Out                  <= 1'b0;
         Frame_Done_Out            <= 1'b0;
         fifo.Fifo_Read_Enable_Out <= 1'b0;
      end else begin
         state                     <= state_next;
         baud_cnt                  <= baud_next;
         bit_cnt                   <= bit_next;
         shift                     <= shift_next;
         parity                    <= parity_next;
         Tx_Out                    <= tx_next;
         Busy_Out                  <= busy_next;
         Frame_Done_Out            <= done_next;
         fifo.Fifo_Read_Enable_Out <= read_next;
      end
   end

   // Next-state and next-output decode for the frame sequencer
   always_comb begin
      state_next  = state;
      baud_next   = baud_wrap ? '0 : baud_cnt + BAUD_W'(1);
      bit_next    = bit_cnt;
      shift_next  = shift;
      parity_next = parity;
      tx_next     = Tx_Out;
      read_next   = 1'b0;
      done_next   = 1'b0;

      case (state)
         IDLE: begin
            tx_next = 1'b1;
            if (Enable_In && !fifo.Fifo_Empty_In) begin
               read_next  = 1'b1;
               state_next = LOAD;
            end
         end
         LOAD: begin
            // Read data is valid on this edge, one cycle after the pop pulse
            shift_next  = fifo.Fifo_Data_In;
            parity_next = (^fifo.Fifo_Data_In) ^ PARITY_INV;
            bit_next    = 3'd0;
            tx_next     = 1'b0;
            state_next  = START;
         end
         START: begin
            if (baud_wrap) begin
               tx_next    = shift[0];
               state_next = DATA;
            end
         end
         DATA: begin
            if (baud_wrap) begin
               if (bit_cnt == 3'd7) begin
                  if (USE_PARITY) begin
                     tx_next    = parity;
                     state_next = PARITY;
                  end else begin
                     tx_next    = 1'b1;
                     state_next = STOP;
                  end
               end else begin
                  // Next bit is already sitting one place up in the register
                  shift_next = {1'b0, shift[7:1]};
                  tx_next    = shift[1];
                  bit_next   = bit_cnt + 3'd1;
               end
            end
         end
         PARITY: begin
            if (baud_wrap) begin
               tx_next    = 1'b1;
               state_next = STOP;
            end
         end
         STOP: begin
            if (baud_wrap) begin
               tx_next    = 1'b1;
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            tx_next    = 1'b1;
            state_next = IDLE;
         end
      endcase

      // Every bit period starts from a fresh count on entry to a new state
      if (state_next != state) begin
         baud_next = '0;
      end

      busy_next = (state_next != IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_serial_transmitter
// Description : Directed bench for fifo_serial_transmitter: three instances
//               (no parity, even parity, odd parity) each fed by a small
//               queue model that answers pops on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_serial_transmitter;

   localparam int C = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en0, en1, en2;
   logic tx0, tx1, tx2;
   logic busy0, busy1, busy2;
   logic done0, done1, done2;

   int errors = 0;
   int checks = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] q2[$];
   int pops0 = 0, pops1 = 0, pops2 = 0;
   int badpop0 = 0, badpop1 = 0, badpop2 = 0;

   fifo_serial_transmitter_if f0 ();
   fifo_serial_transmitter_if f1 ();
   fifo_serial_transmitter_if f2 ();

   always #5 clk = ~clk;

   fifo_serial_transmitter #(.CLKS_PER_BIT(C), .PARITY_ENABLE(0), .PARITY_ODD(0)) u_np (
      .Clk_In(clk), .Reset_In(rst), .Enable_In(en0), .fifo(f0),
      .Tx_Out(tx0), .Busy_Out(busy0), .Frame_Done_Out(done0));

   fifo_serial_transmitter #(.CLKS_PER_BIT(C), .PARITY_ENABLE(1), .PARITY_ODD(0)) u_ev (
      .Clk_In(clk), .Reset_In(rst), .Enable_In(en1), .fifo(f1),
      .Tx_Out(tx1), .Busy_Out(busy1), .Frame_Done_Out(done1));

   fifo_serial_transmitter #(.CLKS_PER_BIT(C), .PARITY_ENABLE(1), .PARITY_ODD(1)) u_od (
      .Clk_In(clk), .Reset_In(rst), .Enable_In(en2), .fifo(f2),
      .Tx_Out(tx2), .Busy_Out(busy2), .Frame_Done_Out(done2));

   // Queue models: read port updates on the falling edge after a pop request
   always @(negedge clk) begin
      if (f0.Fifo_Read_Enable_Out === 1'b1) begin
         pops0++;
         if (q0.size() == 0) badpop0++; else f0.Fifo_Data_In = q0.pop_front();
      end
      f0.Fifo_Empty_In = (q0.size() == 0);
   end

   always @(negedge clk) begin
      if (f1.Fifo_Read_Enable_Out === 1'b1) begin
         pops1++;
         if (q1.size() == 0) badpop1++; else f1.Fifo_Data_In = q1.pop_front();
      end
      f1.Fifo_Empty_In = (q1.size() == 0);
   end

   always @(negedge clk) begin
      if (f2.Fifo_Read_Enable_Out === 1'b1) begin
         pops2++;
         if (q2.size() == 0) badpop2++; else f2.Fifo_Data_In = q2.pop_front();
      end
      f2.Fifo_Empty_In = (q2.size() == 0);
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic tx_of(input int s);
      case (s)
         0:       return tx0;
         1:       return tx1;
         default: return tx2;
      endcase
   endfunction

   function automatic logic busy_of(input int s);
      case (s)
         0:       return busy0;
         1:       return busy1;
         default: return busy2;
      endcase
   endfunction

   function automatic logic done_of(input int s);
      case (s)
         0:       return done0;
         1:       return done1;
         default: return done2;
      endcase
   endfunction

   // Receive one frame: call on a falling edge. slots[k] is the line level in
   // bit slot k; start_wait counts falling edges until the start bit shows;
   // done_at is the cycle distance from the start edge to the done pulse.
   task automatic rx_frame(input int s, input int nslots, output logic [10:0] slots,
                           output int start_wait, output int done_at);
      int t;
      int cyc;
      int busy_bad;
      slots    = '0;
      t        = 0;
      busy_bad = 0;
      done_at  = -1;
      while (tx_of(s) !== 1'b0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      start_wait = t;
      if (tx_of(s) !== 1'b0) begin
         check_value("start_timeout", 1, 0);
         return;
      end
      for (int k = 0; k < nslots; k++) begin
         repeat ((k == 0) ? 1 : C) @(negedge clk);
         slots[k] = tx_of(s);
         if (busy_of(s) !== 1'b1) busy_bad++;
      end
      cyc = 1 + (nslots - 1) * C;
      while (done_of(s) !== 1'b1 && cyc < nslots * C + 20) begin
         @(negedge clk);
         cyc++;
         if (done_of(s) !== 1'b1 && busy_of(s) !== 1'b1) busy_bad++;
      end
      if (done_of(s) === 1'b1) done_at = cyc;
      check_value("busy_in_frame", busy_bad, 0);
      check_value("busy_at_end", {31'd0, busy_of(s)}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] slots;
      logic [7:0]  stream_bytes [3];
      int          sw, da, p, t, idle_bad;

      stream_bytes[0] = 8'h00;
      stream_bytes[1] = 8'hFF;
      stream_bytes[2] = 8'h3C;
      en0 = 1'b0;
      en1 = 1'b0;
      en2 = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check_value("rst_tx", {31'd0, tx0}, 1);
      check_value("rst_busy", {31'd0, busy0}, 0);
      check_value("rst_done", {31'd0, done0}, 0);
      check_value("rst_pop", {31'd0, f0.Fifo_Read_Enable_Out}, 0);
      rst = 1'b0;

      // Enabled but empty for 100 cycles: line idle, no pops
      en0 = 1'b1;
      idle_bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx0 !== 1'b1 || f0.Fifo_Read_Enable_Out !== 1'b0 || busy0 !== 1'b0) idle_bad++;
      end
      check_value("empty_idle", idle_bad, 0);
      check_value("empty_pops", pops0, 0);

      // Single 0xA5, no parity: slots 0,1,0,1,0,0,1,0,1,1
      q0.push_back(8'hA5);
      rx_frame(0, 10, slots, sw, da);
      check_value("a5_slots", {22'd0, slots[9:0]}, 32'h34A);
      check_value("a5_done_at", da, 40);
      check_value("a5_pops", pops0, 1);
      @(negedge clk);
      check_value("a5_done_pulse", {31'd0, done0}, 0);
      check_value("a5_tx_idle", {31'd0, tx0}, 1);

      // 0xA5 with even parity (parity slot 0) and odd parity (slot 1)
      en1 = 1'b1;
      q1.push_back(8'hA5);
      rx_frame(1, 11, slots, sw, da);
      check_value("even_slots", {21'd0, slots}, 32'h54A);
      check_value("even_done_at", da, 44);
      check_value("even_pops", pops1, 1);
      en2 = 1'b1;
      q2.push_back(8'hA5);
      rx_frame(2, 11, slots, sw, da);
      check_value("odd_slots", {21'd0, slots}, 32'h74A);
      check_value("odd_done_at", da, 44);

      // Streaming three bytes back to back
      repeat (10) @(negedge clk);
      p = pops0;
      q0.push_back(8'h00);
      q0.push_back(8'hFF);
      q0.push_back(8'h3C);
      for (int i = 0; i < 3; i++) begin
         rx_frame(0, 10, slots, sw, da);
         check_value("stream_byte", {24'd0, slots[8:1]}, {24'd0, stream_bytes[i]});
         check_value("stream_framing", {30'd0, slots[9], slots[0]}, 2'b10);
         check_value("stream_done_at", da, 40);
         if (i > 0) check_value("stream_gap", sw, 2);
      end
      repeat (30) @(negedge clk);
      check_value("stream_pops", pops0 - p, 3);
      check_value("stream_badpop", badpop0, 0);
      check_value("stream_idle_tx", {31'd0, tx0}, 1);

      // Drop enable mid-frame with two bytes queued
      p = pops0;
      q0.push_back(8'h11);
      q0.push_back(8'h22);
      fork
         rx_frame(0, 10, slots, sw, da);
         begin
            repeat (20) @(negedge clk);
            en0 = 1'b0;
         end
      join
      check_value("dis_byte", {24'd0, slots[8:1]}, 32'h11);
      check_value("dis_done_at", da, 40);
      repeat (50) @(negedge clk);
      check_value("dis_pops", pops0 - p, 1);
      check_value("dis_left", q0.size(), 1);
      check_value("dis_tx", {31'd0, tx0}, 1);
      check_value("dis_busy", {31'd0, busy0}, 0);

      // Reset during data bit 3 of 0x22 (bit 3 is 0), then 0x5A must follow
      p = pops0;
      q0.push_back(8'h5A);
      en0 = 1'b1;
      t = 0;
      while (tx0 !== 1'b0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      check_value("rstm_start_seen", {31'd0, tx0}, 0);
      repeat (17) @(negedge clk);
      check_value("rstm_pre_tx", {31'd0, tx0}, 0);
      check_value("rstm_pre_busy", {31'd0, busy0}, 1);
      #2 rst = 1'b1;
      #1;
      check_value("rstm_tx_async", {31'd0, tx0}, 1);
      check_value("rstm_busy_async", {31'd0, busy0}, 0);
      repeat (3) @(negedge clk);
      check_value("rstm_no_pop", {31'd0, f0.Fifo_Read_Enable_Out}, 0);
      rst = 1'b0;
      rx_frame(0, 10, slots, sw, da);
      check_value("rstm_next_slots", {22'd0, slots[9:0]}, 32'h2B4);
      check_value("rstm_next_done_at", da, 40);
      repeat (20) @(negedge clk);
      check_value("rstm_pops", pops0 - p, 2);
      check_value("rstm_queue_empty", q0.size(), 0);
      check_value("badpop_all", badpop0 + badpop1 + badpop2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
